// File: rtl/binary_median_window_filter.sv
// binary_median_window_filter
// Slides a WIN x WIN window across an IMG_W x IMG_H 1-bit image held in an
// external pixel memory. Every window pixel is fetched with one read, the set
// pixels are counted, and one output pixel per window origin is written: it
// is set when the count of ones exceeds THRESH (majority / binary median).
// All outputs are registered. Output registers are loaded from the next-state
// values, so each output reflects the state the FSM is entering that cycle.
module binary_median_window_filter #(
    parameter int IMG_W  = 240,
    parameter int IMG_H  = 180,
    parameter int WIN    = 3,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1,
    parameter int THRESH = (WIN * WIN) / 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_x,
    output logic [ADDR_W-1:0] rd_addr_y,
    input  logic              rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_x,
    output logic [ADDR_W-1:0] wr_addr_y,
    output logic              wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       window_count
);

    // ------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------
    localparam int NPIX  = WIN * WIN;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int OFF_W = $clog2(WIN);
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(IMG_W - WIN);
    localparam logic [ADDR_W-1:0] Y_LAST   = ADDR_W'(IMG_H - WIN);
    localparam logic [OFF_W-1:0]  OFF_LAST = OFF_W'(WIN - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  THR      = CNT_W'(THRESH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Majority decision on a finished window count.
    function automatic logic f_majority(input logic [CNT_W-1:0] cnt);
        return (cnt > THR);
    endfunction

    // Zero-extend a window offset to address width.
    function automatic logic [ADDR_W-1:0] f_off_ext(input logic [OFF_W-1:0] off);
        return {{(ADDR_W - OFF_W){1'b0}}, off};
    endfunction

    // ------------------------------------------------------------------
    // State and working registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [ADDR_W-1:0]   r_x;
    logic [ADDR_W-1:0]   r_y;
    logic [OFF_W-1:0]    r_i;
    logic [OFF_W-1:0]    r_j;
    logic [LAT_W-1:0]    r_lat;
    logic [CNT_W-1:0]    r_count;
    logic [RD_LAT-1:0]   r_vld;

    // Output registers
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr_x;
    logic [ADDR_W-1:0]   r_rd_addr_y;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr_x;
    logic [ADDR_W-1:0]   r_wr_addr_y;
    logic                r_wr_data;
    logic                r_busy;
    logic                r_done;
    logic [15:0]         r_window_count;

    // Next-state values
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_x_nxt;
    logic [ADDR_W-1:0]   w_y_nxt;
    logic [OFF_W-1:0]    w_i_nxt;
    logic [OFF_W-1:0]    w_j_nxt;
    logic [LAT_W-1:0]    w_lat_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [15:0]         w_wcnt_nxt;

    // Sample accumulation: rd_data only counts when the delayed strobe says
    // it answers one of our reads; the AND keeps an undriven bus out of count.
    logic                w_sample;
    logic [CNT_W-1:0]    w_count_acc;

    assign w_sample    = r_vld[RD_LAT-1] & rd_data;
    assign w_count_acc = r_count + {{(CNT_W - 1){1'b0}}, w_sample};

    // Next-state, origin/offset stepping and counter updates.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_lat_nxt   = r_lat;
        w_count_nxt = w_count_acc;
        w_wcnt_nxt  = r_window_count;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_x_nxt     = {ADDR_W{1'b0}};
                    w_y_nxt     = {ADDR_W{1'b0}};
                    w_i_nxt     = {OFF_W{1'b0}};
                    w_j_nxt     = {OFF_W{1'b0}};
                    w_count_nxt = {CNT_W{1'b0}};
                    w_wcnt_nxt  = 16'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_FETCH: begin
                // Row-major walk: j is the inner (column) offset.
                if (r_j == OFF_LAST) begin
                    w_j_nxt = {OFF_W{1'b0}};
                    if (r_i == OFF_LAST) begin
                        w_i_nxt     = {OFF_W{1'b0}};
                        w_lat_nxt   = {LAT_W{1'b0}};
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_i_nxt = r_i + {{(OFF_W - 1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_j_nxt = r_j + {{(OFF_W - 1){1'b0}}, 1'b1};
                end
            end

            S_DRAIN: begin
                // Wait out the memory latency so the last sample lands.
                if (r_lat == LAT_LAST) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_lat_nxt = r_lat + {{(LAT_W - 1){1'b0}}, 1'b1};
                end
            end

            S_WRITE: begin
                if (wr_ready) begin
                    w_wcnt_nxt  = r_window_count + 16'd1;
                    w_count_nxt = {CNT_W{1'b0}};
                    w_i_nxt     = {OFF_W{1'b0}};
                    w_j_nxt     = {OFF_W{1'b0}};
                    if (r_x < X_LAST) begin
                        w_x_nxt     = r_x + {{(ADDR_W - 1){1'b0}}, 1'b1};
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_x_nxt = {ADDR_W{1'b0}};
                        if (r_y < Y_LAST) begin
                            w_y_nxt     = r_y + {{(ADDR_W - 1){1'b0}}, 1'b1};
                            w_state_nxt = S_FETCH;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end else begin
                    w_state_nxt = S_WRITE;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, origin, offsets, drain counter and ones count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= {ADDR_W{1'b0}};
            r_y     <= {ADDR_W{1'b0}};
            r_i     <= {OFF_W{1'b0}};
            r_j     <= {OFF_W{1'b0}};
            r_lat   <= {LAT_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_lat   <= w_lat_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Read-valid delay line: bit RD_LAT-1 marks the cycle rd_data is ours.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= {RD_LAT{1'b0}};
        end else begin
            r_vld[0] <= r_rd_en;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    // Registered outputs derived from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_en        <= 1'b0;
            r_rd_addr_x    <= {ADDR_W{1'b0}};
            r_rd_addr_y    <= {ADDR_W{1'b0}};
            r_wr_en        <= 1'b0;
            r_wr_addr_x    <= {ADDR_W{1'b0}};
            r_wr_addr_y    <= {ADDR_W{1'b0}};
            r_wr_data      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_window_count <= 16'd0;
        end else begin
            r_rd_en        <= (w_state_nxt == S_FETCH);
            r_rd_addr_x    <= w_x_nxt + f_off_ext(w_j_nxt);
            r_rd_addr_y    <= w_y_nxt + f_off_ext(w_i_nxt);
            r_wr_en        <= (w_state_nxt == S_WRITE);
            r_wr_addr_x    <= w_x_nxt;
            r_wr_addr_y    <= w_y_nxt;
            // Result is latched on entry to WRITE and held through a stall.
            if (w_state_nxt == S_WRITE) begin
                r_wr_data <= f_majority(w_count_nxt);
            end else begin
                r_wr_data <= r_wr_data;
            end
            r_busy         <= (w_state_nxt != S_IDLE);
            r_done         <= (w_state_nxt == S_DONE);
            r_window_count <= w_wcnt_nxt;
        end
    end

    assign rd_en        = r_rd_en;
    assign rd_addr_x    = r_rd_addr_x;
    assign rd_addr_y    = r_rd_addr_y;
    assign wr_en        = r_wr_en;
    assign wr_addr_x    = r_wr_addr_x;
    assign wr_addr_y    = r_wr_addr_y;
    assign wr_data      = r_wr_data;
    assign busy         = r_busy;
    assign done         = r_done;
    assign window_count = r_window_count;

endmodule

// File: tb/tb_binary_median_window_filter.sv
// Directed testbench for binary_median_window_filter.
// DUT A: 8x6 image, 3x3 window, RD_LAT=1 (default timing, 11-cycle period).
// DUT B: 7x7 image, 5x5 window, RD_LAT=3 (29-cycle period).
// Both share one image array; only one DUT runs a pass at a time.
module tb_binary_median_window_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, reset_b;
    logic        a_start, a_rd_en, a_rd_data, a_wr_en, a_wr_data, a_wr_ready, a_busy, a_done;
    logic [7:0]  a_rd_addr_x, a_rd_addr_y, a_wr_addr_x, a_wr_addr_y;
    logic [15:0] a_window_count;
    logic        b_start, b_rd_en, b_rd_data, b_wr_en, b_wr_data, b_wr_ready, b_busy, b_done;
    logic [7:0]  b_rd_addr_x, b_rd_addr_y, b_wr_addr_x, b_wr_addr_y;
    logic [15:0] b_window_count;
    logic [2:0]  b_pipe;

    logic        img [0:7][0:7];
    int          n_checks = 0;
    int          n_errors = 0;

    // Observation mux: sel=0 watches DUT A, sel=1 watches DUT B.
    logic        sel;
    logic        m_rd_en, m_wr_en, m_wr_data, m_busy, m_done;
    logic [7:0]  m_rd_addr_x, m_rd_addr_y, m_wr_addr_x, m_wr_addr_y;
    logic [15:0] m_window_count;

    assign m_rd_en        = sel ? b_rd_en        : a_rd_en;
    assign m_wr_en        = sel ? b_wr_en        : a_wr_en;
    assign m_wr_data      = sel ? b_wr_data      : a_wr_data;
    assign m_busy         = sel ? b_busy         : a_busy;
    assign m_done         = sel ? b_done         : a_done;
    assign m_rd_addr_x    = sel ? b_rd_addr_x    : a_rd_addr_x;
    assign m_rd_addr_y    = sel ? b_rd_addr_y    : a_rd_addr_y;
    assign m_wr_addr_x    = sel ? b_wr_addr_x    : a_wr_addr_x;
    assign m_wr_addr_y    = sel ? b_wr_addr_y    : a_wr_addr_y;
    assign m_window_count = sel ? b_window_count : a_window_count;

    binary_median_window_filter #(
        .IMG_W(8), .IMG_H(6), .WIN(3), .ADDR_W(8), .RD_LAT(1)
    ) u_dut_a (
        .clk(clk), .reset(reset_a), .start(a_start),
        .rd_en(a_rd_en), .rd_addr_x(a_rd_addr_x), .rd_addr_y(a_rd_addr_y),
        .rd_data(a_rd_data),
        .wr_en(a_wr_en), .wr_addr_x(a_wr_addr_x), .wr_addr_y(a_wr_addr_y),
        .wr_data(a_wr_data), .wr_ready(a_wr_ready),
        .busy(a_busy), .done(a_done), .window_count(a_window_count)
    );

    binary_median_window_filter #(
        .IMG_W(7), .IMG_H(7), .WIN(5), .ADDR_W(8), .RD_LAT(3)
    ) u_dut_b (
        .clk(clk), .reset(reset_b), .start(b_start),
        .rd_en(b_rd_en), .rd_addr_x(b_rd_addr_x), .rd_addr_y(b_rd_addr_y),
        .rd_data(b_rd_data),
        .wr_en(b_wr_en), .wr_addr_x(b_wr_addr_x), .wr_addr_y(b_wr_addr_y),
        .wr_data(b_wr_data), .wr_ready(b_wr_ready),
        .busy(b_busy), .done(b_done), .window_count(b_window_count)
    );

    // Pixel memories: return the addressed pixel RD_LAT cycles after a read,
    // random junk in every other cycle.
    always @(posedge clk) begin
        a_rd_data <= a_rd_en ? img[a_rd_addr_y[2:0]][a_rd_addr_x[2:0]] : 1'($urandom);
        b_pipe    <= {b_pipe[1:0], (b_rd_en ? img[b_rd_addr_y[2:0]][b_rd_addr_x[2:0]] : 1'($urandom))};
    end
    assign b_rd_data = b_pipe[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference majority for the window at origin (x,y).
    function automatic logic exp_px(input int x, input int y, input int win, input int thr);
        int c;
        c = 0;
        for (int i = 0; i < win; i++)
            for (int j = 0; j < win; j++)
                c += int'(img[y+i][x+j]);
        return (c > thr);
    endfunction

    // One full pass on the selected DUT.
    // mode 0: wr_ready always 1; mode 1: random wr_ready;
    // mode 2: wr_ready low for the first 5 cycles of the first write.
    // xstart: cycle at which a stray start pulse is given (0 = none).
    // ex0/ex1: hand-computed first/second wr_data (-1 = skip).
    task automatic run_pass(input bit s, input int mode, input int xstart, input int ex0, input int ex1);
        int win, thr, wlim, hlim, core, nexp, cyc, nwr, nrd, ox, oy, ri, rj;
        int en_cnt, prev_acc, ndone, lx, ly;
        bit rdy, fin;
        logic [16:0] held;
        win  = s ? 5 : 3;
        thr  = s ? 12 : 4;
        wlim = s ? 2 : 5;
        hlim = s ? 2 : 3;
        core = win * win + (s ? 3 : 1);
        nexp = (wlim + 1) * (hlim + 1);
        sel  = s;
        if (s) b_start = 1'b1; else a_start = 1'b1;
        @(posedge clk);
        cyc = 1; nwr = 0; nrd = 0; ox = 0; oy = 0; ri = 0; rj = 0;
        en_cnt = 0; prev_acc = 0; ndone = 0; lx = 0; ly = 0; fin = 1'b0; held = '0;
        while (!fin) begin
            @(negedge clk);
            if (s) b_start = (cyc == xstart); else a_start = (cyc == xstart);
            if (cyc == 1) begin
                check_val("first_rd_en", 32'(m_rd_en), 32'd1);
                check_val("busy_rise", 32'(m_busy), 32'd1);
            end
            if (m_rd_en) begin
                check_val("rd_addr", {16'd0, m_rd_addr_x, m_rd_addr_y}, {16'd0, 8'(ox + rj), 8'(oy + ri)});
                nrd++; rj++;
                if (rj == win) begin rj = 0; ri++; end
            end
            rdy = 1'b1;
            if (en_cnt != 0) check_val("wr_en_held", 32'(m_wr_en), 32'd1);
            if (m_wr_en) begin
                check_val("rd_during_wr", 32'(m_rd_en), 32'd0);
                if (en_cnt == 0) begin
                    check_val("wr_cycle", 32'(cyc), 32'(prev_acc + core + 1));
                    check_val("reads_per_win", 32'(nrd), 32'(win * win));
                    check_val("wr_addr", {16'd0, m_wr_addr_x, m_wr_addr_y}, {16'd0, 8'(ox), 8'(oy)});
                    held = {m_wr_addr_x, m_wr_addr_y, m_wr_data};
                end else begin
                    check_val("wr_hold", 32'({m_wr_addr_x, m_wr_addr_y, m_wr_data}), 32'(held));
                end
                if (mode == 2 && nwr == 0) rdy = (en_cnt >= 5);
                else if (mode == 1) rdy = 1'($urandom_range(0, 1));
                en_cnt++;
                if (rdy) begin
                    check_val("wr_data", 32'(m_wr_data), 32'(exp_px(ox, oy, win, thr)));
                    if (nwr == 0 && ex0 >= 0) check_val("first_data", 32'(m_wr_data), 32'(ex0));
                    if (nwr == 1 && ex1 >= 0) check_val("second_data", 32'(m_wr_data), 32'(ex1));
                    if (mode == 2 && nwr == 0) check_val("stall_len", 32'(en_cnt), 32'd6);
                    check_val("win_count_run", 32'(m_window_count), 32'(nwr));
                    lx = m_wr_addr_x; ly = m_wr_addr_y;
                    nwr++; prev_acc = cyc; en_cnt = 0; nrd = 0; ri = 0; rj = 0;
                    if (ox < wlim) ox++;
                    else begin ox = 0; oy++; end
                end
            end
            if (s) b_wr_ready = rdy; else a_wr_ready = rdy;
            if (m_done) begin
                ndone++;
                check_val("done_cycle", 32'(cyc), 32'(prev_acc + 1));
                check_val("last_origin", 32'({lx[7:0], ly[7:0]}), 32'({wlim[7:0], hlim[7:0]}));
            end else if (ndone > 0) begin
                check_val("busy_fall", 32'(m_busy), 32'd0);
                fin = 1'b1;
            end
            if (cyc > 3000) begin
                check_val("timeout", 32'(cyc), 32'd3000);
                fin = 1'b1;
            end
            cyc++;
        end
        check_val("done_pulses", 32'(ndone), 32'd1);
        check_val("writes", 32'(nwr), 32'(nexp));
        check_val("window_count", 32'(m_window_count), 32'(nexp));
    endtask

    initial begin
        sel = 1'b0;
        reset_a = 1'b1; reset_b = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_wr_ready = 1'b0; b_wr_ready = 1'b0;
        b_pipe = 3'd0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                img[y][x] = 1'b1;

        // Reset for 3 cycles: every output low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_rd_en", 32'(a_rd_en), 32'd0);
        check_val("rst_rd_addr", 32'({a_rd_addr_x, a_rd_addr_y}), 32'd0);
        check_val("rst_wr_en", 32'(a_wr_en), 32'd0);
        check_val("rst_wr_addr", 32'({a_wr_addr_x, a_wr_addr_y}), 32'd0);
        check_val("rst_wr_data", 32'(a_wr_data), 32'd0);
        check_val("rst_busy", 32'(a_busy), 32'd0);
        check_val("rst_done", 32'(a_done), 32'd0);
        check_val("rst_win_count", 32'(a_window_count), 32'd0);
        check_val("rst_b_outputs", {b_rd_en, b_wr_en, b_wr_data, b_busy, b_done,
                                    b_rd_addr_x[2:0], b_rd_addr_y[2:0], b_wr_addr_x[2:0],
                                    b_wr_addr_y[2:0], b_window_count}, 32'd0);
        reset_a = 1'b0; reset_b = 1'b0;
        @(negedge clk);

        // All-ones image, wr_ready high, stray start during FETCH.
        run_pass(1'b0, 0, 4, 1, 1);

        // Threshold boundary: (0,0) holds 4 ones, (1,0) holds 5 ones.
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                img[y][x] = 1'b0;
        img[0][1] = 1'b1; img[1][1] = 1'b1;
        img[0][2] = 1'b1; img[1][2] = 1'b1;
        img[0][3] = 1'b1;
        run_pass(1'b0, 0, 0, 0, 1);

        // Random image with random back-pressure.
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                img[y][x] = 1'($urandom);
        run_pass(1'b0, 1, 0, -1, -1);

        // DUT B image: window (0,0) holds exactly 12 ones (= THRESH) -> 0.
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                img[y][x] = (y < 2) || (y == 2 && x < 2);

        // Reset in the middle of FETCH while reads of ones are in flight.
        sel = 1'b1;
        b_wr_ready = 1'b1;
        b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset_b = 1'b1;
        @(posedge clk);
        #1 reset_b = 1'b0;
        @(negedge clk);
        check_val("midrst_busy", 32'(b_busy), 32'd0);
        check_val("midrst_rd_en", 32'(b_rd_en), 32'd0);
        check_val("midrst_win_count", 32'(b_window_count), 32'd0);

        // Fresh pass on B with a 5-cycle stall on the first write.
        run_pass(1'b1, 2, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/binary_median_window_filter.md
# binary_median_window_filter

Parametrised binary median filter engine for the image-filter datapath. It slides a WIN×WIN window across an IMG_W×IMG_H 1‑bit image held in external pixel memory, issues one read per window pixel, and counts the set pixels. For each window origin it writes one output pixel, which is set when the count exceeds THRESH. It supersedes the fixed 3×3 / 240×180 engine with configurable geometry, configurable memory read latency, registered outputs and a write-side ready handshake.

## Interface
Parameters:
- IMG_W, 240, image width in pixels
- IMG_H, 180, image height in pixels
- WIN, 3, window edge; odd, 3..7, WIN ≤ IMG_W and WIN ≤ IMG_H
- ADDR_W, 8, width of x/y address ports; must hold IMG_W-1 and IMG_H-1
- RD_LAT, 1, pixel memory read latency in cycles, 1..4
- THRESH, (WIN*WIN)/2, output is 1 when the count of ones > THRESH
- Constraint: (IMG_W-WIN+1)*(IMG_H-WIN+1) ≤ 65535

Ports:
- clk  in  1  clock; single clock domain; reset is synchronous and active-high
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a full-image pass; sampled only in IDLE
- rd_en  out  1  pixel read strobe
- rd_addr_x  out  ADDR_W  read column = origin x + window column offset j
- rd_addr_y  out  ADDR_W  read row = origin y + window row offset i
- rd_data  in  1  pixel value, valid exactly RD_LAT cycles after its rd_en
- wr_en  out  1  output pixel valid
- wr_addr_x  out  ADDR_W  window origin x (top-left)
- wr_addr_y  out  ADDR_W  window origin y
- wr_data  out  1  median (majority) result
- wr_ready  in  1  sink accepts the write when wr_en && wr_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a pass
- window_count  out  16  number of writes accepted in the current or last pass

## Operation
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 → FETCH; origin set to (0,0), offsets i=j=0, count=0, window_count=0.
  - start in any other state is ignored.
- FETCH:
  - rd_en=1 for exactly WIN*WIN consecutive cycles, row-major (j inner, i outer).
  - After the last read (i=j=WIN-1) → DRAIN.
- Valid tracking:
  - An RD_LAT-deep shift register delays rd_en.
  - rd_data is added to count only when the delayed bit is set; at all other times rd_data is ignored (X tolerated).
  - count width is clog2(WIN*WIN+1).
- DRAIN: held for RD_LAT cycles so the last sample is accumulated, then → WRITE.
- WRITE:
  - wr_en=1, wr_addr = origin, wr_data = (count > THRESH).
  - All three outputs are held stable until wr_ready=1.
  - No reads are issued while in WRITE.
- On an accepted write:
  - window_count increments; count clears; i=j=0.
  - If origin x < IMG_W-WIN: x+1 → FETCH.
  - Else x=0; if y < IMG_H-WIN: y+1 → FETCH.
  - Else (last window) → DONE.
- DONE: done=1 for one cycle → IDLE. window_count holds its value until the next accepted start.
- Reset at any time: state → IDLE, valid shift register cleared, count cleared. Read data still in flight is discarded.

## Timing
- All outputs are registered.
- Reset values: rd_en=0, rd_addr_x/y=0, wr_en=0, wr_addr_x/y=0, wr_data=0, busy=0, done=0, window_count=0.
- start sampled in cycle t → first rd_en in cycle t+1. busy rises with FETCH.
- Window period with wr_ready held high: WIN*WIN + RD_LAT + 1 cycles. Defaults give 3×3 → 11 cycles.
- First wr_en appears at cycle t+1+WIN*WIN+RD_LAT. Defaults: t+11.
- Each cycle wr_ready is low adds one cycle to the period. wr_en is not dropped.
- done is asserted the cycle after the last write is accepted. busy falls the cycle after done.

## Test plan
- Reset/idle:
  - Assert reset for 3 cycles → every output 0.
  - Pulse start in FETCH → ignored; window_count unchanged by the extra start.
- All-ones image, defaults, wr_ready=1:
  - 42364 writes, all wr_data=1, 11-cycle period.
  - First write at (0,0) in cycle t+11.
  - Exactly one done pulse; window_count=42364.
- Threshold boundary, defaults:
  - Window (0,0) containing exactly 4 ones → wr_data=0.
  - Window (1,0) containing exactly 5 ones → wr_data=1.
- RD_LAT=3, wr_ready low for 5 cycles on the first write:
  - wr_en/addr/data stable for 6 cycles; rd_en stays 0 throughout.
  - Count is correct using the delayed samples.
- Raster wrap, defaults:
  - Write at (237,0) → next read origin (0,1).
  - Last write (237,177) → done pulse on the next cycle.
  - WIN=5 run: last origin (235,175).
- Reset mid-FETCH with reads in flight, then start:
  - First window count is computed from fresh samples only; no stale carry-over.
  - window_count restarts from 0.
